// File: rtl/bridge_pkg.sv
// Shared constants for the AHB-to-APB bridge: peripheral regions, select width, FSM encoding.
package bridge_pkg;

  localparam int PSEL_W = 3;

  localparam logic [31:0] R0_BASE  = 32'h8000_0000;
  localparam logic [31:0] R0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] R1_BASE  = 32'h8400_0000;
  localparam logic [31:0] R1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] R2_BASE  = 32'h8800_0000;
  localparam logic [31:0] R2_LIMIT = 32'h8BFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decode: byte address to one-hot peripheral select plus hit flag.
module apb_addr_decode
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [PSEL_W-1:0] psel,
  output logic              hit
);

  logic [31:0] addr32_s;

  assign addr32_s = 32'(addr);

  // Region match; regions are disjoint so priority order is irrelevant.
  always_comb begin
    psel = '0;
    if (in_region(addr32_s, R0_BASE, R0_LIMIT)) begin
      psel = 3'b001;
    end else if (in_region(addr32_s, R1_BASE, R1_LIMIT)) begin
      psel = 3'b010;
    end else if (in_region(addr32_s, R2_BASE, R2_LIMIT)) begin
      psel = 3'b100;
    end else begin
      psel = 3'b000;
    end
    hit = |psel;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: accepts one request at a time, runs SETUP/ACCESS, returns a one-cycle response.
module apb_master_ctrl
  import bridge_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [PSEL_W-1:0] psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_e              state_q, state_d;
  logic [PSEL_W-1:0]   psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [PSEL_W-1:0]   dec_psel_s;
  logic                dec_hit_s;

  apb_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr (req_addr),
    .psel (dec_psel_s),
    .hit  (dec_hit_s)
  );

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          pwrite_d = req_write;
          if (dec_hit_s) begin
            state_d    = ST_SETUP;
            psel_d     = dec_psel_s;
            wait_cnt_d = '0;
          end else begin
            state_d     = ST_ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d     = ST_DONE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = (pwrite_q || pslverr) ? '0 : prdata;
        end else if (wait_cnt_q == CNT_LAST) begin
          // Slave never answered: release the bus and report a timeout.
          state_d     = ST_DONE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl (WAIT_MAX=4); outputs sampled 1ns after each rising edge.
module tb_apb_master_ctrl;

  logic        hclk;
  logic        hreset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_checks = 0;
  int n_pass   = 0;

  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(4)) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Present one request; it is accepted at the next edge since the controller is idle.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    check("idle_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  // Zero-wait transfer with full phase checks; exp_psel==0 means unmapped.
  task automatic do_xfer(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [2:0] exp_psel, input logic exp_err,
                         input logic [31:0] exp_rdata);
    issue(wr, addr, 32'h1111_2222);
    if (exp_psel == 3'b000) begin
      check({tag, "_err_psel"}, {61'd0, psel}, 64'd0);
      check({tag, "_err_pen"}, {63'd0, penable}, 64'd0);
    end else begin
      check({tag, "_setup_psel"}, {61'd0, psel}, {61'd0, exp_psel});
      check({tag, "_setup_pen"}, {63'd0, penable}, 64'd0);
      check({tag, "_setup_rv"}, {63'd0, rsp_valid}, 64'd0);
      tick();
      check({tag, "_acc_psel"}, {61'd0, psel}, {61'd0, exp_psel});
      check({tag, "_acc_pen"}, {63'd0, penable}, 64'd1);
      tick();
      check({tag, "_done_psel"}, {61'd0, psel}, 64'd0);
    end
    check({tag, "_rv"}, {63'd0, rsp_valid}, 64'd1);
    check({tag, "_err"}, {63'd0, rsp_err}, {63'd0, exp_err});
    check({tag, "_rdata"}, {32'd0, rsp_rdata}, {32'd0, exp_rdata});
    tick();
    check({tag, "_rv_drop"}, {63'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    hreset    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    prdata    = 32'd0;
    pready    = 1'b1;
    pslverr   = 1'b0;
    tick();
    tick();
    check("rst_psel", {61'd0, psel}, 64'd0);
    check("rst_pen", {63'd0, penable}, 64'd0);
    check("rst_paddr", {32'd0, paddr}, 64'd0);
    check("rst_pwdata", {32'd0, pwdata}, 64'd0);
    check("rst_rv", {63'd0, rsp_valid}, 64'd0);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    hreset = 1'b0;
    tick();

    // Write, zero wait: SETUP at T+1, ACCESS at T+2, response at T+3.
    issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    check("wr_setup_psel", {61'd0, psel}, 64'd1);
    check("wr_setup_pen", {63'd0, penable}, 64'd0);
    check("wr_paddr", {32'd0, paddr}, 64'h8000_0010);
    check("wr_pwdata", {32'd0, pwdata}, 64'hDEAD_BEEF);
    check("wr_pwrite", {63'd0, pwrite}, 64'd1);
    check("wr_busy", {63'd0, req_ready}, 64'd0);
    prdata = 32'hAAAA_5555;
    tick();
    check("wr_acc_pen", {63'd0, penable}, 64'd1);
    check("wr_acc_psel", {61'd0, psel}, 64'd1);
    tick();
    check("wr_rv", {63'd0, rsp_valid}, 64'd1);
    check("wr_err", {63'd0, rsp_err}, 64'd0);
    check("wr_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("wr_release", {62'd0, psel[0], penable}, 64'd0);
    tick();
    check("wr_rv_drop", {63'd0, rsp_valid}, 64'd0);
    check("wr_ready_t4", {63'd0, req_ready}, 64'd1);

    // Read with two wait cycles; a pslverr while pready is low must be ignored.
    pready = 1'b0;
    issue(1'b0, 32'h8400_0004, 32'd0);
    check("rd_setup_psel", {61'd0, psel}, 64'd2);
    pslverr = 1'b1;
    tick();
    check("rd_acc1_pen", {63'd0, penable}, 64'd1);
    pslverr = 1'b0;
    tick();
    check("rd_acc2_pen", {63'd0, penable}, 64'd1);
    check("rd_acc2_rv", {63'd0, rsp_valid}, 64'd0);
    tick();
    check("rd_acc3_pen", {63'd0, penable}, 64'd1);
    pready = 1'b1;
    prdata = 32'd25;
    tick();
    check("rd_rv", {63'd0, rsp_valid}, 64'd1);
    check("rd_rdata", {32'd0, rsp_rdata}, 64'd25);
    check("rd_err", {63'd0, rsp_err}, 64'd0);
    tick();

    // Read with slave error.
    issue(1'b0, 32'h8800_0000, 32'd0);
    check("se_setup_psel", {61'd0, psel}, 64'd4);
    tick();
    pslverr = 1'b1;
    prdata  = 32'h0000_0077;
    tick();
    check("se_rv", {63'd0, rsp_valid}, 64'd1);
    check("se_err", {63'd0, rsp_err}, 64'd1);
    check("se_rdata", {32'd0, rsp_rdata}, 64'd0);
    pslverr = 1'b0;
    tick();

    // Unmapped address and region-edge decode table.
    prdata = 32'h0000_0042;
    do_xfer("unm", 1'b0, 32'h9000_0000, 3'b000, 1'b1, 32'd0);
    do_xfer("r0_top", 1'b0, 32'h83FF_FFFF, 3'b001, 1'b0, 32'h42);
    do_xfer("r1_top", 1'b0, 32'h87FF_FFFF, 3'b010, 1'b0, 32'h42);
    do_xfer("r2_top", 1'b1, 32'h8BFF_FFFF, 3'b100, 1'b0, 32'd0);
    do_xfer("past_r2", 1'b0, 32'h8C00_0000, 3'b000, 1'b1, 32'd0);
    do_xfer("below_r0", 1'b0, 32'h7FFF_FFFF, 3'b000, 1'b1, 32'd0);

    // Timeout: WAIT_MAX=4 ACCESS cycles, then forced completion.
    pready = 1'b0;
    prdata = 32'h0000_00FF;
    issue(1'b0, 32'h8000_0100, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("to_acc%0d_pen", i + 1), {63'd0, penable}, 64'd1);
      check($sformatf("to_acc%0d_rv", i + 1), {63'd0, rsp_valid}, 64'd0);
    end
    tick();
    check("to_rv", {63'd0, rsp_valid}, 64'd1);
    check("to_err", {63'd0, rsp_err}, 64'd1);
    check("to_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("to_release", {60'd0, psel, penable}, 64'd0);
    tick();

    // Reset in the middle of ACCESS aborts without a response.
    issue(1'b0, 32'h8000_0200, 32'd0);
    tick();
    check("ra_acc_pen", {63'd0, penable}, 64'd1);
    #2;
    hreset = 1'b1;
    #1;
    check("ra_psel_async", {61'd0, psel}, 64'd0);
    check("ra_pen_async", {63'd0, penable}, 64'd0);
    tick();
    hreset = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ra_rv%0d", i), {63'd0, rsp_valid}, 64'd0);
      check($sformatf("ra_ready%0d", i), {63'd0, req_ready}, 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
